unified_mem_arbiter: RTL and testbench

- Arbitrates a single-port unified memory between the pipeline's instruction-fetch port (IF) and data port (MEM stage loads/stores).
- Sits between the pipelined datapath and the external memory model.
- Serialises accesses through a request/ack FSM and emits per-port stall levels; the pipeline freezes PC/IF latch and the EX/MEM advance from these.
- Fixed data-over-fetch priority, with a starvation guard for fetch and a per-access ack timeout.

---
 rtl/unified_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and data access.
// Data has priority; a starvation guard forces fetch, and a per-access timeout aborts a silent memory.
module unified_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_d,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic       owner_d;          // 1: current access belongs to the data port
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    logic       grant_d, grant_if, acked, timed_out;

    assign stall_if = if_req & ~if_ready;
    assign stall_d  = d_req & ~d_ready;

    always_comb begin
        state_nx  = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        acked     = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || starve_cnt < STARVE_LIM))
                    grant_d = 1'b1;
                else if (if_req)
                    grant_if = 1'b1;
                if (grant_d || grant_if)
                    state_nx = BUSY;
            end
            BUSY: begin
                // A coincident ack takes precedence over the timeout.
                if (mem_ack)
                    acked = 1'b1;
                else if (tmo_cnt == TMO_LAST)
                    timed_out = 1'b1;
                if (acked || timed_out)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d || grant_if) begin
                        owner_d   <= grant_d;
                        mem_req   <= 1'b1;
                        mem_we    <= grant_d & d_we;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        tmo_cnt   <= '0;
                        if (grant_d && if_req)
                            starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
                        else
                            starve_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (acked || timed_out) begin
                        mem_req  <= 1'b0;
                        tmo_cnt  <= '0;
                        if_ready <= ~owner_d;
                        d_ready  <= owner_d;
                        if (!owner_d)
                            if_rdata <= acked ? mem_rdata : '0;
                        else if (!mem_we)
                            d_rdata <= acked ? mem_rdata : '0;
                        if (timed_out)
                            err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter, directed scenarios, then random traffic.
module tb_unified_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SM    = 4;
    localparam int TO    = 16;
    localparam int NOACK = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          stall_if, stall_d;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          err;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_d(stall_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    // Model: one outstanding access described by grant cycle, ack latency and owner.
    int            cyc;
    bit            act;
    bit            own_d;
    int            g_cyc, lat, end_cyc;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata, ack_data;
    logic [DW-1:0] m_if_rdata, m_d_rdata;
    bit            m_err;
    int            consec_d;
    bit            grant_log[$];

    int            plan_lat;
    logic [DW-1:0] plan_data;
    bit            rnd_mode, rnd_stop;
    int            d_repeat;
    int            cool_if, cool_d;
    int            mreq_cnt;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        act = 0; m_addr = '0; m_we = 0; m_wdata = '0;
        m_if_rdata = '0; m_d_rdata = '0; m_err = 0; consec_d = 0; cyc = 0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        mem_ack = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        if_req = 0; d_req = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic requesters(input bit done_if, input bit done_d);
        if (!rnd_mode) begin
            if (done_if) if_req = 0;
            if (done_d) begin
                if (d_repeat > 0) begin
                    d_repeat--;
                    d_addr = d_addr + 4;
                end else d_req = 0;
            end
            return;
        end
        if (done_if) begin
            if (!rnd_stop && $urandom_range(2) == 0) if_addr = $urandom();
            else begin if_req = 0; cool_if = $urandom_range(4); end
        end else if (if_req) begin
            if ($urandom_range(3) == 0) if_addr = $urandom();
        end else if (!rnd_stop) begin
            if (cool_if == 0) begin if_req = 1; if_addr = $urandom(); end
            else cool_if--;
        end
        if (done_d) begin
            if (!rnd_stop && $urandom_range(1) == 0) begin
                d_addr = $urandom(); d_we = 1'($urandom_range(1)); d_wdata = $urandom();
            end else begin d_req = 0; cool_d = $urandom_range(3); end
        end else if (d_req) begin
            if ($urandom_range(3) == 0) begin
                d_addr = $urandom(); d_we = 1'($urandom_range(1)); d_wdata = $urandom();
            end
        end else if (!rnd_stop) begin
            if (cool_d == 0) begin
                d_req = 1; d_addr = $urandom(); d_we = 1'($urandom_range(1)); d_wdata = $urandom();
            end else cool_d--;
        end
    endtask

    // One clock cycle: compare outputs against the model, advance the model, drive the next inputs.
    task automatic step();
        bit e_req, e_ir, e_dr, done_if, done_d;
        int r;
        e_req = act && cyc > g_cyc && cyc <= end_cyc;
        e_ir  = act && cyc == end_cyc + 1 && !own_d;
        e_dr  = act && cyc == end_cyc + 1 && own_d;
        @(negedge clk);
        if (mem_req) mreq_cnt++;
        chk("mem_req", mem_req, e_req);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_ready", if_ready, e_ir);
        chk("d_ready", d_ready, e_dr);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("stall_if", stall_if, if_req & ~e_ir);
        chk("stall_d", stall_d, d_req & ~e_dr);
        chk("err", err, m_err);
        @(posedge clk);
        done_if = 0; done_d = 0;
        if (act) begin
            if (cyc == end_cyc) begin
                if (lat <= TO) begin
                    if (!own_d) m_if_rdata = ack_data;
                    else if (!m_we) m_d_rdata = ack_data;
                end else begin
                    m_err = 1;
                    if (!own_d) m_if_rdata = '0;
                    else if (!m_we) m_d_rdata = '0;
                end
            end else if (cyc == end_cyc + 1) begin
                act = 0; done_if = !own_d; done_d = own_d;
            end
        end else if (if_req || d_req) begin
            own_d    = d_req && (!if_req || consec_d < SM);
            consec_d = (own_d && if_req) ? consec_d + 1 : 0;
            m_addr   = own_d ? d_addr : if_addr;
            m_we     = own_d ? d_we : 1'b0;
            m_wdata  = own_d ? d_wdata : '0;
            if (plan_lat != 0) begin
                lat = plan_lat; ack_data = plan_data;
            end else begin
                r = $urandom_range(19);
                lat = (r < 2) ? NOACK : (r == 2) ? TO : $urandom_range(6, 1);
                ack_data = $urandom();
            end
            act = 1; g_cyc = cyc;
            end_cyc = g_cyc + ((lat <= TO) ? lat : TO);
            grant_log.push_back(own_d);
        end
        cyc++;
        #1;
        mem_ack   = act && lat <= TO && cyc == g_cyc + lat;
        mem_rdata = mem_ack ? ack_data : $urandom();
        requesters(done_if, done_d);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((act || if_req || d_req) && n < max) begin
            step();
            n++;
        end
        chk("drain_bound", n < max, 1);
    endtask

    initial begin
        int ls;
        logic [DW-1:0] d_before;
        rnd_mode = 0; rnd_stop = 0; d_repeat = 0; plan_lat = 0; plan_data = '0;
        cool_if = 0; cool_d = 0; mreq_cnt = 0;
        g_cyc = 0; lat = 0; end_cyc = 0; own_d = 0; ack_data = '0;
        model_reset();
        do_reset();

        // Fetch only, zero-wait memory.
        plan_lat = 1; plan_data = 32'h8C01_0004;
        if_req = 1; if_addr = 32'h0000_0040;
        step();
        #2;
        chk("fetch_mem_req_c1", mem_req, 1);
        chk("fetch_mem_addr_c1", mem_addr, 32'h40);
        chk("fetch_mem_we_c1", mem_we, 0);
        chk("fetch_stall_c1", stall_if, 1);
        step();
        #2;
        chk("fetch_if_ready_c2", if_ready, 1);
        chk("fetch_if_rdata_c2", if_rdata, 32'h8C01_0004);
        chk("fetch_stall_c2", stall_if, 0);
        chk("fetch_model_rdata", m_if_rdata, 32'h8C01_0004);
        drain(20);

        // Collision: data store first, fetch right after.
        plan_lat = 2; plan_data = 32'h5555_AAAA;
        d_before = m_d_rdata;
        ls = grant_log.size();
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        if_req = 1; if_addr = 32'h80;
        step();
        #2;
        chk("coll_mem_we", mem_we, 1);
        chk("coll_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("coll_mem_addr", mem_addr, 32'h100);
        drain(40);
        chk("coll_first_data", grant_log[ls], 1);
        chk("coll_second_fetch", grant_log[ls+1], 0);
        chk("coll_d_rdata_kept", d_rdata, d_before);

        // Starvation: D,D,D,D then fetch forced.
        plan_lat = 1; plan_data = 32'h0BAD_F00D;
        ls = grant_log.size();
        d_repeat = 4; d_req = 1; d_we = 0; d_addr = 32'h300; if_req = 1; if_addr = 32'h84;
        drain(100);
        chk("starve_g0", grant_log[ls], 1);
        chk("starve_g1", grant_log[ls+1], 1);
        chk("starve_g2", grant_log[ls+2], 1);
        chk("starve_g3", grant_log[ls+3], 1);
        chk("starve_g4_fetch", grant_log[ls+4], 0);
        chk("starve_g5", grant_log[ls+5], 1);

        // Timeout on a load, then a normal fetch.
        plan_lat = NOACK; mreq_cnt = 0;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        drain(40);
        chk("tmo_mem_req_cycles", mreq_cnt, 16);
        chk("tmo_err", err, 1);
        chk("tmo_d_rdata", d_rdata, 0);
        plan_lat = 3; plan_data = 32'h1357_9BDF;
        if_req = 1; if_addr = 32'h88;
        drain(20);
        chk("tmo_fetch_rdata", if_rdata, 32'h1357_9BDF);
        chk("tmo_err_sticky", err, 1);

        // Ack on the last BUSY cycle beats the timeout.
        do_reset();
        plan_lat = 16; plan_data = 32'h1234_5678;
        d_req = 1; d_we = 0; d_addr = 32'h204;
        drain(40);
        chk("coinc_d_rdata", d_rdata, 32'h1234_5678);
        chk("coinc_err", err, 0);

        // Reset in the middle of a busy access.
        plan_lat = NOACK;
        d_req = 1; d_we = 0; d_addr = 32'h208;
        step(); step(); step();
        do_reset();
        for (int i = 0; i < 20; i++) step();

        // Random traffic.
        plan_lat = 0; rnd_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        rnd_stop = 1;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
